// File: rtl/trace_pkg.sv
// Shared types and record-field helpers for the trace capture/replay pair.
// Records carry the timestamp in the top 32 bits and the payload below it.
package trace_pkg;

  localparam int unsigned TS_WIDTH  = 32;
  localparam int unsigned JTAG_WORD = 32;
  // Helpers take records zero-extended to this width so one function serves any record width.
  localparam int unsigned MAX_REC_W = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StFin
  } state_e;

  function automatic logic [TS_WIDTH-1:0] rec_ts(input logic [MAX_REC_W-1:0] rec,
                                                 input int unsigned w);
    logic [MAX_REC_W-1:0] s;
    s = rec >> (w - TS_WIDTH);
    return s[TS_WIDTH-1:0];
  endfunction

  function automatic logic [MAX_REC_W-1:0] rec_payload(input logic [MAX_REC_W-1:0] rec,
                                                       input int unsigned w);
    return rec & ({MAX_REC_W{1'b1}} >> (MAX_REC_W - w + TS_WIDTH));
  endfunction

  // Wraparound-safe "timer has reached ts".
  function automatic logic ts_due(input logic [TS_WIDTH-1:0] timer,
                                  input logic [TS_WIDTH-1:0] ts);
    logic [TS_WIDTH-1:0] d;
    d = timer - ts;
    return ~d[TS_WIDTH-1];
  endfunction

endpackage

// File: rtl/trace_bram.sv
// Simple dual-port record store: one write port, one registered read port.
module trace_bram #(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 1024
) (
  input  logic                     CLK,
  input  logic                     i_we,
  input  logic [$clog2(depth)-1:0] i_waddr,
  input  logic [width-1:0]         i_wdata,
  input  logic [$clog2(depth)-1:0] i_raddr,
  output logic [width-1:0]         o_rdata
);

  logic [width-1:0] r_mem [depth];
  logic [width-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_word_packer.sv
// Assembles 32-bit host words, most-significant first, into width-bit records.
module trace_word_packer #(
  parameter int unsigned width = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [31:0]      i_word,
  output logic [width-1:0] o_rec,
  output logic             o_rec_done,
  output logic             o_idx_zero
);

  localparam int unsigned W  = width / 32;
  localparam int unsigned IW = $clog2(W);

  logic [IW-1:0]       r_idx;
  logic [width-33:0]   r_shift;
  logic                w_last;

  assign w_last     = (r_idx == IW'(W - 1));
  assign o_rec      = {r_shift, i_word};
  assign o_rec_done = i_accept && w_last && !i_clear;
  assign o_idx_zero = (r_idx == '0);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_accept) begin
      r_shift <= o_rec[width-33:0];
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trace_replay.sv
// Loads timestamped records from the JTAG pipe into BRAM and replays each
// payload on data_out when a free-running timer reaches its timestamp.
module trace_replay
  import trace_pkg::*;
#(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 1024
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   fromJtag_enq__ENA,
  input  logic [31:0]            fromJtag_enq_v,
  output logic                   fromJtag_enq__RDY,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  output logic [width-33:0]      data_out,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(depth):0] record_count,
  output logic [7:0]             late_count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = width - 32;

  state_e              r_state, w_state_nxt;
  logic [CW-1:0]       r_count, r_paddr, w_paddr_inc;
  logic [width-1:0]    r_hold, w_rdata, w_rec;
  logic [MAX_REC_W-1:0] w_hold_ext, w_rdata_ext;
  logic [TS_WIDTH-1:0] r_timer, w_ts;
  logic [PW-1:0]       r_data_out, w_payload;
  logic [7:0]          r_late;
  logic                r_valid, r_busy, r_done;
  logic                w_idle, w_accept, w_clear, w_rec_done, w_idx_zero;
  logic                w_start_ok, w_stop, w_due, w_emit;

  assign w_idle            = (r_state == StIdle);
  assign fromJtag_enq__RDY = w_idle && (r_count != CW'(depth));
  assign w_accept          = fromJtag_enq__ENA && fromJtag_enq__RDY;
  assign w_clear           = clear && w_idle;
  assign w_stop            = stop && !w_idle;
  assign w_start_ok        = start && w_idle && w_idx_zero && !stop;

  assign w_hold_ext  = MAX_REC_W'(r_hold);
  assign w_rdata_ext = MAX_REC_W'(w_rdata);
  assign w_ts        = rec_ts(w_hold_ext, width);
  assign w_payload   = PW'(rec_payload(w_hold_ext, width));
  assign w_due       = ts_due(r_timer, w_ts);
  assign w_emit      = (r_state == StWait) && w_due && !stop;
  assign w_paddr_inc = r_paddr + 1'b1;

  trace_word_packer #(
    .width(width)
  ) u_packer (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_clear   (w_clear),
    .i_accept  (w_accept),
    .i_word    (fromJtag_enq_v),
    .o_rec     (w_rec),
    .o_rec_done(w_rec_done),
    .o_idx_zero(w_idx_zero)
  );

  trace_bram #(
    .width(width),
    .depth(depth)
  ) u_bram (
    .CLK    (CLK),
    .i_we   (w_rec_done),
    .i_waddr(r_count[AW-1:0]),
    .i_wdata(w_rec),
    .i_raddr(r_paddr[AW-1:0]),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_nxt = (r_count == '0) ? StFin : StFetch;
      StFetch: w_state_nxt = StLoad;
      StLoad:  w_state_nxt = StWait;
      StWait:  if (w_due) w_state_nxt = (w_paddr_inc == r_count) ? StFin : StFetch;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_stop) w_state_nxt = StIdle;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_paddr    <= '0;
      r_hold     <= '0;
      r_timer    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_late     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_emit;
      if (w_emit) r_data_out <= w_payload;

      if (w_clear)         r_count <= '0;
      else if (w_rec_done) r_count <= r_count + 1'b1;

      if (w_start_ok)  r_paddr <= '0;
      else if (w_emit) r_paddr <= w_paddr_inc;

      if (w_start_ok)                          r_busy <= 1'b1;
      else if (w_stop || r_state == StFin)     r_busy <= 1'b0;

      if (w_stop)                              r_done <= 1'b0;
      else if (r_state == StFin)               r_done <= 1'b1;
      else if (w_clear || w_start_ok)          r_done <= 1'b0;

      if (w_start_ok)                                          r_late <= '0;
      else if (w_emit && r_timer != w_ts && r_late != 8'hff)   r_late <= r_late + 8'd1;

      if (r_state == StLoad) r_hold <= w_rdata;
      // Record 0 aligns the timer to its own timestamp so it goes out with zero wait.
      if (r_state == StLoad && r_paddr == '0) r_timer <= rec_ts(w_rdata_ext, width);
      else if (!w_idle)                       r_timer <= r_timer + 32'd1;
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign record_count = r_count;
  assign late_count   = r_late;

endmodule
